// File: rtl/apb4_plic.sv
// Single-context PLIC: level gateways, priority arbiter, APB4 slave.
// Side effects fire once per transfer, on the first access cycle.
module apb4_plic #(
  parameter int          NSRC   = 8,
  parameter int          PRIO_W = 3,
  parameter logic [31:0] BASE   = 32'h1000_0000
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            PSEL,
  input  logic            PENABLE,
  input  logic [31:0]     PADDR,
  input  logic            PWRITE,
  input  logic [3:0]      PSTRB,
  input  logic [31:0]     PWDATA,
  output logic [31:0]     PRDATA,
  output logic            PREADY,
  output logic            PSLVERR,
  input  logic [NSRC-1:0] src,
  output logic            irq,
  output logic            r_overflow,
  output logic            w_overflow
);

  localparam int IW = $clog2(NSRC + 1);

  localparam logic [29:0] W_PEND = 30'h0000_0400;
  localparam logic [29:0] W_EN   = 30'h0000_0800;
  localparam logic [29:0] W_THR  = 30'h0008_0000;
  localparam logic [29:0] W_CLM  = 30'h0008_0001;

  logic              acc, acc_q, first;
  logic              rd_en, wr_en;
  logic [31:0]       off, wmask, wd, rdata;
  logic [29:0]       word;
  logic              aligned, mapped;
  logic              hit_prio, hit_pend, hit_en;
  logic              hit_thr, hit_clm;

  logic [PRIO_W-1:0] prio [NSRC];
  logic [NSRC-1:0]   en, pend, insvc;
  logic [PRIO_W-1:0] thr;
  logic [IW-1:0]     max_id, claim_q;
  logic              irq_q;

  logic [IW-1:0]     best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [NSRC-1:0]   claim_v, comp_v;

  assign acc   = PSEL & PENABLE;
  assign first = acc & ~acc_q;
  assign rd_en = first & ~PWRITE;
  assign wr_en = first & PWRITE;

  assign off     = PADDR - BASE;
  assign word    = off[31:2];
  assign aligned = (off[1:0] == 2'b00);

  assign hit_prio = aligned && (word <= 30'(NSRC));
  assign hit_pend = aligned && (word == W_PEND);
  assign hit_en   = aligned && (word == W_EN);
  assign hit_thr  = aligned && (word == W_THR);
  assign hit_clm  = aligned && (word == W_CLM);
  assign mapped   = hit_prio | hit_pend | hit_en
                  | hit_thr | hit_clm;

  assign wmask = {{8{PSTRB[3]}}, {8{PSTRB[2]}},
                  {8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign wd    = PWDATA & wmask;

  assign PREADY     = 1'b1;
  assign PSLVERR    = acc & ~mapped;
  assign r_overflow = PSLVERR & ~PWRITE;
  assign w_overflow = PSLVERR & PWRITE;
  assign irq        = irq_q;
  assign PRDATA     = rdata;

  // Strict '>' keeps the lowest ID on priority ties.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pend[i] && en[i] && (prio[i] > thr)
          && (prio[i] > best_prio)) begin
        best_id   = IW'(i + 1);
        best_prio = prio[i];
      end
    end
  end

  always_comb begin
    claim_v = '0;
    comp_v  = '0;
    for (int i = 0; i < NSRC; i++) begin
      claim_v[i] = rd_en & hit_clm
                 & (max_id == IW'(i + 1));
      comp_v[i]  = wr_en & hit_clm & insvc[i]
                 & (wd == 32'(i + 1));
    end
  end

  // Claim data is latched so a held read stays stable.
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_prio: begin
        for (int i = 0; i < NSRC; i++) begin
          if (word == 30'(i + 1))
            rdata[PRIO_W-1:0] = prio[i];
        end
      end
      hit_pend: rdata[NSRC:0] = {pend, 1'b0};
      hit_en:   rdata[NSRC:0] = {en, 1'b0};
      hit_thr:  rdata[PRIO_W-1:0] = thr;
      hit_clm:  rdata[IW-1:0] = first ? max_id : claim_q;
      default:  rdata = '0;
    endcase
    if (!(acc && !PWRITE))
      rdata = '0;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      acc_q   <= 1'b0;
      en      <= '0;
      thr     <= '0;
      pend    <= '0;
      insvc   <= '0;
      max_id  <= '0;
      claim_q <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < NSRC; i++)
        prio[i] <= '0;
    end else begin
      acc_q  <= acc;
      max_id <= best_id;
      irq_q  <= (best_id != '0);

      if (wr_en) begin
        for (int i = 0; i < NSRC; i++) begin
          if (hit_prio && (word == 30'(i + 1)))
            prio[i] <= (prio[i] & ~wmask[PRIO_W-1:0])
                     | wd[PRIO_W-1:0];
        end
        if (hit_en)
          en <= (en & ~wmask[NSRC:1]) | wd[NSRC:1];
        if (hit_thr)
          thr <= (thr & ~wmask[PRIO_W-1:0])
               | wd[PRIO_W-1:0];
      end

      if (rd_en && hit_clm)
        claim_q <= max_id;

      // Claim/complete beat a same-edge level rise.
      for (int i = 0; i < NSRC; i++) begin
        if (claim_v[i]) begin
          pend[i]  <= 1'b0;
          insvc[i] <= 1'b1;
        end else if (comp_v[i]) begin
          insvc[i] <= 1'b0;
        end else if (src[i] && !pend[i] && !insvc[i]) begin
          pend[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb4_plic.sv
// Directed bench for apb4_plic: register table plus
// hand-written claim/complete, threshold and reset sequences.
module tb_apb4_plic;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [7:0]  src = '0;
  logic        irq, r_overflow, w_overflow;

  int n_chk = 0;
  int n_pass = 0;

  localparam logic [31:0] A_PEND = 32'h1000_1000;
  localparam logic [31:0] A_EN   = 32'h1000_2000;
  localparam logic [31:0] A_THR  = 32'h1020_0000;
  localparam logic [31:0] A_CLM  = 32'h1020_0004;
  localparam logic [31:0] A_BAD  = 32'h1000_3000;

  apb4_plic dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE),
    .PSTRB(PSTRB), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .src(src), .irq(irq),
    .r_overflow(r_overflow), .w_overflow(w_overflow)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t v[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h",
                  name, act, exp);
  endtask

  task automatic apb(input  logic        wr,
                     input  logic [31:0] a,
                     input  logic [3:0]  s,
                     input  logic [31:0] d,
                     input  int          hold,
                     output logic [31:0] rd0,
                     output logic [31:0] rdn,
                     output logic        e,
                     output logic        ro,
                     output logic        wo);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0;
    PADDR = a; PWRITE = wr; PSTRB = s; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    rd0 = PRDATA; e = PSLVERR;
    ro = r_overflow; wo = w_overflow;
    rdn = rd0;
    for (int k = 1; k < hold; k++) begin
      @(negedge PCLK);
      #1;
      rdn = PRDATA;
    end
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PSTRB = '0;
  endtask

  task automatic rd(input string name,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    logic [31:0] r0, rn;
    logic e, ro, wo;
    apb(1'b0, a, 4'h0, 32'h0, 1, r0, rn, e, ro, wo);
    check(name, r0, exp);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [3:0]  s,
                    input logic [31:0] d);
    logic [31:0] r0, rn;
    logic e, ro, wo;
    apb(1'b1, a, s, d, 1, r0, rn, e, ro, wo);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  initial begin
    logic [31:0] r0, rn;
    logic e, ro, wo;

    // reset reads
    v.push_back('{1'b0, 32'h1000_0000, 4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, 32'h1000_0004, 4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, 32'h1000_0020, 4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, A_PEND, 4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, A_EN,   4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, A_THR,  4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, A_CLM,  4'h0, 0, 0, 1'b0});
    // configuration
    v.push_back('{1'b1, 32'h1000_0004, 4'hF, 6, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_0008, 4'hF, 7, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_000C, 4'hF, 5, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_0010, 4'hF, 4, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_0014, 4'hF, 3, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_0018, 4'hF, 2, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_001C, 4'hF, 1, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_0020, 4'hF, 0, 0, 1'b0});
    v.push_back('{1'b1, 32'h1000_0000, 4'hF, 7, 0, 1'b0});
    v.push_back('{1'b1, A_EN,  4'hF, 32'h1FF, 0, 1'b0});
    v.push_back('{1'b1, A_THR, 4'hF, 0, 0, 1'b0});
    // unmapped accesses, then readback
    v.push_back('{1'b0, A_BAD, 4'h0, 0, 0, 1'b1});
    v.push_back('{1'b1, A_BAD, 4'hF, 32'hFFFF_FFFF, 0, 1'b1});
    v.push_back('{1'b0, 32'h1000_0024, 4'h0, 0, 0, 1'b1});
    v.push_back('{1'b0, 32'h1000_0000, 4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, 32'h1000_0004, 4'h0, 0, 6, 1'b0});
    v.push_back('{1'b0, 32'h1000_0008, 4'h0, 0, 7, 1'b0});
    v.push_back('{1'b0, 32'h1000_000C, 4'h0, 0, 5, 1'b0});
    v.push_back('{1'b0, 32'h1000_0010, 4'h0, 0, 4, 1'b0});
    v.push_back('{1'b0, 32'h1000_0014, 4'h0, 0, 3, 1'b0});
    v.push_back('{1'b0, 32'h1000_0018, 4'h0, 0, 2, 1'b0});
    v.push_back('{1'b0, 32'h1000_001C, 4'h0, 0, 1, 1'b0});
    v.push_back('{1'b0, 32'h1000_0020, 4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, A_EN,  4'h0, 0, 32'h1FE, 1'b0});
    v.push_back('{1'b0, A_THR, 4'h0, 0, 0, 1'b0});
    v.push_back('{1'b0, A_PEND, 4'h0, 0, 0, 1'b0});

    cyc(3);
    PRESETn = 1'b1;
    cyc(1);
    check("idle_prdata", PRDATA, 0);
    check("idle_pslverr", {31'b0, PSLVERR}, 0);
    check("pready", {31'b0, PREADY}, 1);
    check("reset_irq", {31'b0, irq}, 0);

    foreach (v[i]) begin
      apb(v[i].wr, v[i].addr, v[i].strb, v[i].wdata,
          1, r0, rn, e, ro, wo);
      if (!v[i].wr)
        check($sformatf("vec%0d rdata", i), r0, v[i].exp);
      check($sformatf("vec%0d pslverr", i),
            {31'b0, e}, {31'b0, v[i].err});
      check($sformatf("vec%0d r_ovf", i),
            {31'b0, ro}, {31'b0, v[i].err & ~v[i].wr});
      check($sformatf("vec%0d w_ovf", i),
            {31'b0, wo}, {31'b0, v[i].err & v[i].wr});
    end
    check("irq_cfg", {31'b0, irq}, 0);

    // single source: latency, held claim, re-pend
    src = 8'b0000_0010;
    cyc(1);
    check("irq_lat1", {31'b0, irq}, 0);
    cyc(1);
    check("irq_lat2", {31'b0, irq}, 1);
    rd("pend_id2", A_PEND, 32'h004);
    apb(1'b0, A_CLM, 4'h0, 0, 5, r0, rn, e, ro, wo);
    check("claim_first", r0, 2);
    check("claim_held", rn, 2);
    check("irq_after_claim", {31'b0, irq}, 0);
    rd("pend_after_claim", A_PEND, 0);
    wr(A_CLM, 4'hF, 2);
    cyc(2);
    check("irq_repend", {31'b0, irq}, 1);
    rd("pend_repend", A_PEND, 32'h004);

    // two sources, bad complete ignored
    src = 8'b0000_0110;
    cyc(2);
    rd("claim_prio", A_CLM, 2);
    wr(A_CLM, 4'hF, 3);
    cyc(2);
    rd("pend_badcomp", A_PEND, 32'h008);
    wr(A_CLM, 4'hF, 2);
    cyc(2);
    rd("pend_goodcomp", A_PEND, 32'h00C);

    // threshold
    src = 8'b0000_0100;
    rd("claim_id2_again", A_CLM, 2);
    wr(A_CLM, 4'hF, 2);
    cyc(2);
    rd("pend_only3", A_PEND, 32'h008);
    check("irq_id3", {31'b0, irq}, 1);
    wr(A_THR, 4'hF, 6);
    cyc(2);
    check("irq_thr6", {31'b0, irq}, 0);
    rd("claim_thr6", A_CLM, 0);
    rd("pend_thr6", A_PEND, 32'h008);
    wr(A_THR, 4'hF, 4);
    cyc(2);
    check("irq_thr4", {31'b0, irq}, 1);
    rd("claim_id3", A_CLM, 3);
    src = 8'b0000_0000;
    wr(A_CLM, 4'hF, 3);
    cyc(2);
    check("irq_drained", {31'b0, irq}, 0);
    rd("pend_drained", A_PEND, 0);

    // priority-0 source never interrupts
    wr(A_THR, 4'hF, 0);
    src = 8'b1000_0000;
    cyc(3);
    rd("pend_id8", A_PEND, 32'h100);
    check("irq_id8", {31'b0, irq}, 0);
    rd("claim_id8", A_CLM, 0);

    // byte-lane strobes
    wr(32'h1000_0004, 4'b0001, 32'hFF);
    rd("prio1_strb0", 32'h1000_0004, 7);
    wr(32'h1000_0004, 4'b1110, 32'h0);
    rd("prio1_strb_hi", 32'h1000_0004, 7);
    wr(A_EN, 4'b0010, 32'h0);
    rd("en_strb1", A_EN, 32'h0FE);

    // reset during an access aborts the write
    src = 8'b0000_0000;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 32'h1000_0008; PSTRB = 4'hF; PWDATA = 3;
    @(negedge PCLK);
    PENABLE = 1'b1; PRESETn = 1'b0;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    check("rst_irq", {31'b0, irq}, 0);
    rd("rst_prio2", 32'h1000_0008, 0);
    rd("rst_en", A_EN, 0);
    rd("rst_pend", A_PEND, 0);
    rd("rst_claim", A_CLM, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
